// File: rtl/fetch_decode_if.sv
// Bundle of the instruction-ROM port, redirect request and decoded-instruction
// handshake between the fetch/decode stage and its surroundings.
interface fetch_decode_if;
  logic [7:0] rom_address;
  logic [7:0] rom_data1;
  logic [7:0] rom_data2;
  logic       jump_valid;
  logic [7:0] jump_target;
  logic       dec_valid;
  logic       dec_ready;
  logic [1:0] dec_op;
  logic [3:0] dec_rd;
  logic [3:0] dec_ra;
  logic [3:0] dec_rb;
  logic [7:0] dec_imm;
  logic [7:0] dec_pc;
  logic       halted;

  modport master (
    output rom_address, dec_valid, dec_op, dec_rd, dec_ra, dec_rb,
           dec_imm, dec_pc, halted,
    input  rom_data1, rom_data2, jump_valid, jump_target, dec_ready
  );

  modport slave (
    input  rom_address, dec_valid, dec_op, dec_rd, dec_ra, dec_rb,
           dec_imm, dec_pc, halted,
    output rom_data1, rom_data2, jump_valid, jump_target, dec_ready
  );
endinterface

// File: rtl/fetch_decode.sv
// Two-byte instruction fetch from a combinational ROM with a registered decode
// stage, valid/ready output handshake, redirect and sticky halt on illegal opcodes.
module fetch_decode #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_decode_if.master       bus
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OPC_NOP   = 4'b0000;
  localparam logic [3:0] OPC_LOAD  = 4'b0001;
  localparam logic [3:0] OPC_ADD   = 4'b1000;
  localparam logic [3:0] OPC_STORE = 4'b0011;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic       vld_q, vld_d;
  logic [1:0] op_q, op_d;
  logic [3:0] rd_q, rd_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] dpc_q, dpc_d;
  logic       halted_q, halted_d;

  logic       can_capture;
  logic       legal;
  logic [3:0] opc;

  assign opc         = bus.rom_data1[7:4];
  assign legal       = (opc == OPC_NOP) || (opc == OPC_LOAD) ||
                       (opc == OPC_ADD) || (opc == OPC_STORE);
  assign can_capture = !vld_q || bus.dec_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    vld_d    = vld_q;
    op_d     = op_q;
    rd_d     = rd_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    imm_d    = imm_q;
    dpc_d    = dpc_q;
    halted_d = halted_q;

    case (state_q)
      // The first edge after release behaves exactly like RUN, so the
      // instruction at RESET_PC is captured immediately.
      ST_RESET, ST_RUN: begin
        state_d = ST_RUN;
        if (bus.jump_valid) begin
          pc_d  = {bus.jump_target[7:1], 1'b0};
          vld_d = 1'b0;
        end else if (can_capture) begin
          if (legal) begin
            vld_d = 1'b1;
            dpc_d = pc_q;
            pc_d  = pc_q + 8'd2;
            op_d  = 2'd0;
            rd_d  = 4'd0;
            ra_d  = 4'd0;
            rb_d  = 4'd0;
            imm_d = 8'd0;
            case (opc)
              OPC_LOAD: begin
                op_d  = 2'd1;
                rd_d  = bus.rom_data1[3:0];
                imm_d = bus.rom_data2;
              end
              OPC_ADD: begin
                op_d = 2'd2;
                ra_d = bus.rom_data1[3:0];
                rb_d = bus.rom_data2[7:4];
                rd_d = bus.rom_data2[3:0];
              end
              OPC_STORE: begin
                op_d  = 2'd3;
                ra_d  = bus.rom_data1[3:0];
                imm_d = bus.rom_data2;
              end
              default: ;
            endcase
          end else begin
            // Any pending instruction is accepted on this edge; the illegal
            // one is never issued and the PC stays pointing at it.
            vld_d    = 1'b0;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      pc_q     <= RESET_PC;
      vld_q    <= 1'b0;
      op_q     <= 2'd0;
      rd_q     <= 4'd0;
      ra_q     <= 4'd0;
      rb_q     <= 4'd0;
      imm_q    <= 8'd0;
      dpc_q    <= 8'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      vld_q    <= vld_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      imm_q    <= imm_d;
      dpc_q    <= dpc_d;
      halted_q <= halted_d;
    end
  end

  assign bus.rom_address = pc_q;
  assign bus.dec_valid   = vld_q;
  assign bus.dec_op      = op_q;
  assign bus.dec_rd      = rd_q;
  assign bus.dec_ra      = ra_q;
  assign bus.dec_rb      = rb_q;
  assign bus.dec_imm     = imm_q;
  assign bus.dec_pc      = dpc_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: streaming, back-pressure, redirect, illegal
// opcode halt, PC wrap and asynchronous mid-run reset.
module tb_fetch_decode;

  logic       clk;
  logic       reset;
  logic [7:0] rom [256];
  logic [7:0] addr_p1;
  int         checks;
  int         failures;

  fetch_decode_if bus ();

  fetch_decode #(.RESET_PC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign addr_p1       = bus.rom_address + 8'd1;
  assign bus.rom_data1 = rom[bus.rom_address];
  assign bus.rom_data2 = rom[addr_p1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dec(input string tag, input logic [1:0] op, input logic [3:0] rd,
                           input logic [3:0] ra, input logic [3:0] rb,
                           input logic [7:0] imm, input logic [7:0] pc);
    check_eq({tag, ".valid"}, bus.dec_valid, 1'b1);
    check_eq({tag, ".op"},    bus.dec_op, op);
    check_eq({tag, ".rd"},    bus.dec_rd, rd);
    check_eq({tag, ".ra"},    bus.dec_ra, ra);
    check_eq({tag, ".rb"},    bus.dec_rb, rb);
    check_eq({tag, ".imm"},   bus.dec_imm, imm);
    check_eq({tag, ".pc"},    bus.dec_pc, pc);
  endtask

  initial begin
    logic [7:0] prog [12];
    checks   = 0;
    failures = 0;
    prog = '{8'h00, 8'h00, 8'h10, 8'hFF, 8'h11, 8'h01,
             8'h12, 8'hF8, 8'h80, 8'h13, 8'h33, 8'h82};
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < 12; i++) rom[i] = prog[i];
    rom[12]  = 8'hF0;
    rom[254] = 8'h10;
    rom[255] = 8'hAA;

    reset           = 1'b0;
    bus.dec_ready   = 1'b1;
    bus.jump_valid  = 1'b0;
    bus.jump_target = 8'h00;

    #2;
    check_eq("rst.rom_address", bus.rom_address, 8'h00);
    check_eq("rst.dec_valid",   bus.dec_valid, 1'b0);
    check_eq("rst.halted",      bus.halted, 1'b0);
    check_eq("rst.dec_op",      bus.dec_op, 2'd0);
    check_eq("rst.dec_imm",     bus.dec_imm, 8'h00);
    step();
    step();
    check_eq("rst.hold_valid",  bus.dec_valid, 1'b0);

    @(negedge clk);
    reset = 1'b1;

    // Streaming start
    step();
    check_dec("nop0", 2'd0, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00);
    check_eq("nop0.rom_address", bus.rom_address, 8'h02);
    step();
    check_dec("load2", 2'd1, 4'd0, 4'd0, 4'd0, 8'hFF, 8'h02);

    // Back-pressure for 3 cycles on LOAD@2
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_dec("bp.load2", 2'd1, 4'd0, 4'd0, 4'd0, 8'hFF, 8'h02);
      check_eq("bp.rom_address", bus.rom_address, 8'h04);
    end
    bus.dec_ready = 1'b1;
    step();
    check_dec("load4", 2'd1, 4'd1, 4'd0, 4'd0, 8'h01, 8'h04);
    step();
    check_dec("load6", 2'd1, 4'd2, 4'd0, 4'd0, 8'hF8, 8'h06);
    step();
    check_dec("add8", 2'd2, 4'd3, 4'd0, 4'd1, 8'h00, 8'h08);
    check_eq("add8.rom_address", bus.rom_address, 8'h0A);

    // Redirect to odd target 09 while ADD@8 pending
    bus.jump_valid  = 1'b1;
    bus.jump_target = 8'h09;
    step();
    bus.jump_valid = 1'b0;
    check_eq("jmp.dec_valid",   bus.dec_valid, 1'b0);
    check_eq("jmp.rom_address", bus.rom_address, 8'h08);
    step();
    check_dec("add8.reissue", 2'd2, 4'd3, 4'd0, 4'd1, 8'h00, 8'h08);
    step();
    check_dec("store10", 2'd3, 4'd0, 4'd3, 4'd0, 8'h82, 8'h0A);
    check_eq("store10.rom_address", bus.rom_address, 8'h0C);

    // Illegal opcode at 12
    step();
    check_eq("ill.halted",      bus.halted, 1'b1);
    check_eq("ill.dec_valid",   bus.dec_valid, 1'b0);
    check_eq("ill.rom_address", bus.rom_address, 8'h0C);
    for (int i = 0; i < 10; i++) begin
      bus.jump_valid  = (i % 2 == 0);
      bus.jump_target = 8'h40;
      bus.dec_ready   = (i % 3 != 0);
      step();
      check_eq("halt.rom_address", bus.rom_address, 8'h0C);
      check_eq("halt.dec_valid",   bus.dec_valid, 1'b0);
      check_eq("halt.halted",      bus.halted, 1'b1);
    end
    bus.jump_valid = 1'b0;
    bus.dec_ready  = 1'b1;

    // Reset out of HALT, asynchronously
    reset = 1'b0;
    #1;
    check_eq("halt_rst.halted",      bus.halted, 1'b0);
    check_eq("halt_rst.rom_address", bus.rom_address, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_dec("wrap.nop0", 2'd0, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00);

    // Wrap test: jump to FE
    bus.jump_valid  = 1'b1;
    bus.jump_target = 8'hFE;
    step();
    bus.jump_valid = 1'b0;
    check_eq("wrap.flush_valid", bus.dec_valid, 1'b0);
    check_eq("wrap.rom_fe",      bus.rom_address, 8'hFE);
    step();
    check_dec("wrap.loadFE", 2'd1, 4'd0, 4'd0, 4'd0, 8'hAA, 8'hFE);
    check_eq("wrap.rom_address", bus.rom_address, 8'h00);

    // Mid-run asynchronous reset between edges while dec_valid=1
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst.dec_valid",   bus.dec_valid, 1'b0);
    check_eq("mid_rst.halted",      bus.halted, 1'b0);
    check_eq("mid_rst.rom_address", bus.rom_address, 8'h00);
    check_eq("mid_rst.dec_pc",      bus.dec_pc, 8'h00);
    check_eq("mid_rst.dec_op",      bus.dec_op, 2'd0);
    check_eq("mid_rst.dec_imm",     bus.dec_imm, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
